// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: reset vector, NOP encoding and the
// stage-register entry used by IF/ID and ID/EX.
package pipe_pkg;

  localparam int          XLEN      = 32;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
  localparam logic [31:0] RESET_PC  = 32'h0001_0000;
  localparam logic [31:0] RESET_PC4 = RESET_PC + 32'd4;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc4;
    logic [XLEN-1:0] instr;
  } ifid_entry_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter for pipeline performance statistics; sticks at
// all-ones instead of wrapping.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] count_r;

  // count register, frozen once it reaches the maximum
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count_r <= '0;
    end else if (inc && (count_r != CNT_MAX)) begin
      count_r <= count_r + CNT_ONE;
    end else begin
      count_r <= count_r;
    end
  end

  assign count = count_r;

endmodule

// File: rtl/ifid_skid_reg.sv
// IF/ID stage register with a one-entry skid buffer so a fetch already in
// flight is not lost while ID is held; flush kills both entries.
module ifid_skid_reg #(
  parameter int               WIDTH     = 32,
  parameter int               CNT_W     = 16,
  parameter logic [WIDTH-1:0] NOP_INSTR = pipe_pkg::NOP_INSTR,
  parameter logic [WIDTH-1:0] RESET_PC4 = pipe_pkg::RESET_PC4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_pc4,
  input  logic [WIDTH-1:0] in_instr,
  output logic             in_ready,
  input  logic             flush,
  input  logic             hold,
  output logic             id_valid,
  output logic [WIDTH-1:0] id_pc4,
  output logic [WIDTH-1:0] id_instr,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  import pipe_pkg::*;

  ifid_entry_t out_r;
  ifid_entry_t sk_r;
  ifid_entry_t out_n_s;
  ifid_entry_t sk_n_s;
  ifid_entry_t in_entry_s;
  logic        accept_s;
  logic        advance_s;
  logic        stall_inc_s;

  // ready depends only on the skid flop so IF never sees a comb path from hold
  assign in_ready   = !sk_r.valid;
  assign accept_s   = in_valid & !sk_r.valid;
  assign advance_s  = !hold | !out_r.valid;
  assign in_entry_s = '{valid: 1'b1, pc4: in_pc4, instr: in_instr};

  // next-state for output slot and skid slot: flush > advance > hold
  always_comb begin
    out_n_s = out_r;
    sk_n_s  = sk_r;
    if (flush) begin
      out_n_s.valid = 1'b0;
      out_n_s.instr = NOP_INSTR;
      sk_n_s.valid  = 1'b0;
    end else if (advance_s) begin
      if (sk_r.valid) begin
        out_n_s = sk_r;
        if (accept_s) begin
          sk_n_s = in_entry_s;
        end else begin
          sk_n_s.valid = 1'b0;
        end
      end else if (accept_s) begin
        out_n_s = in_entry_s;
      end else begin
        out_n_s.valid = 1'b0;
        out_n_s.instr = NOP_INSTR;
      end
    end else begin
      if (accept_s) begin
        sk_n_s = in_entry_s;
      end else begin
        sk_n_s = sk_r;
      end
    end
  end

  // slot registers; reset empties both and restores the reset PC+4
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      out_r <= '{valid: 1'b0, pc4: RESET_PC4, instr: NOP_INSTR};
      sk_r  <= '{valid: 1'b0, pc4: {WIDTH{1'b0}}, instr: NOP_INSTR};
    end else begin
      out_r <= out_n_s;
      sk_r  <= sk_n_s;
    end
  end

  assign id_valid = out_r.valid;
  assign id_pc4   = out_r.pc4;
  assign id_instr = out_r.instr;

  assign stall_inc_s = hold & out_r.valid & !flush;

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clock (clock),
    .reset (reset),
    .inc   (stall_inc_s),
    .count (stall_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clock (clock),
    .reset (reset),
    .inc   (flush),
    .count (flush_cnt)
  );

endmodule
